// File: rtl/encrypt_stream.sv
// Lane-parallel LWE encryption engine: accumulates noise-selected public-key entries per row
// and streams DIMENSION+1 ciphertext elements, adding the plaintext term on row 0.
module encrypt_stream #(
  parameter int unsigned PLAINTEXT_WIDTH  = 6,
  parameter int unsigned CIPHERTEXT_WIDTH = 10,
  parameter int unsigned DIMENSION        = 10,
  parameter int unsigned BIG_N            = 30,
  parameter int unsigned LANES            = 5,
  parameter int unsigned PT_SCALE         = 1,
  parameter int unsigned ROW_WIDTH        = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [PLAINTEXT_WIDTH-1:0]        plaintext_i,
  input  logic [BIG_N-1:0]                  noise_select_i,
  output logic                              busy_o,
  input  logic                              pk_valid_i,
  output logic                              pk_ready_o,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0] pk_data_i,
  output logic                              ct_valid_o,
  input  logic                              ct_ready_i,
  output logic [CIPHERTEXT_WIDTH-1:0]       ct_data_o,
  output logic [ROW_WIDTH-1:0]              ct_index_o,
  output logic                              ct_last_o,
  output logic                              done_o
);

  localparam int unsigned CW    = CIPHERTEXT_WIDTH;
  localparam int unsigned PW    = PLAINTEXT_WIDTH;
  localparam int unsigned Beats = BIG_N / LANES;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pt_q, pt_d;
  logic [BIG_N-1:0]      sel_q, sel_d;
  logic [CW-1:0]         acc_q, acc_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [CW-1:0]         ct_data_q, ct_data_d;
  logic [ROW_WIDTH-1:0]  ct_index_q, ct_index_d;
  logic                  done_q, done_d;

  logic [BIG_N-1:0]      sel_shift;
  logic [LANES-1:0]      sel_beat;
  logic [CW-1:0]         partial;
  logic [CW-1:0]         pt_ext;
  logic [CW-1:0]         pt_term;

  // Unselected lanes never enter the sum, so X on those lanes cannot leak.
  always_comb begin
    sel_shift = sel_q >> (32'(beat_q) * LANES);
    sel_beat  = sel_shift[LANES-1:0];
    partial   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (sel_beat[l]) partial = partial + pk_data_i[l*CW +: CW];
    end
  end

  always_comb begin
    pt_ext  = CW'(pt_q);
    pt_term = '0;
    if (row_q == '0) pt_term = (PT_SCALE != 0) ? (pt_ext << (CW - PW)) : pt_ext;
  end

  always_comb begin
    state_d    = state_q;
    pt_d       = pt_q;
    sel_d      = sel_q;
    acc_d      = acc_q;
    row_d      = row_q;
    beat_d     = beat_q;
    ct_data_d  = ct_data_q;
    ct_index_d = ct_index_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pt_d    = plaintext_i;
          sel_d   = noise_select_i;
          row_d   = '0;
          beat_d  = '0;
          acc_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (pk_valid_i) begin
          if (beat_q == BeatW'(Beats - 1)) begin
            ct_data_d  = acc_q + partial + pt_term;
            ct_index_d = row_q;
            beat_d     = '0;
            state_d    = StOutput;
          end else begin
            acc_d  = acc_q + partial;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StOutput: begin
        if (ct_ready_i) begin
          if (row_q == ROW_WIDTH'(DIMENSION)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q + 1'b1;
            acc_d   = '0;
            state_d = StAccum;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pt_q       <= '0;
      sel_q      <= '0;
      acc_q      <= '0;
      row_q      <= '0;
      beat_q     <= '0;
      ct_data_q  <= '0;
      ct_index_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pt_q       <= pt_d;
      sel_q      <= sel_d;
      acc_q      <= acc_d;
      row_q      <= row_d;
      beat_q     <= beat_d;
      ct_data_q  <= ct_data_d;
      ct_index_q <= ct_index_d;
      done_q     <= done_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign pk_ready_o = (state_q == StAccum);
  assign ct_valid_o = (state_q == StOutput);
  assign ct_data_o  = ct_data_q;
  assign ct_index_o = ct_index_q;
  assign ct_last_o  = ct_valid_o && (ct_index_q == ROW_WIDTH'(DIMENSION));
  assign done_o     = done_q;

endmodule

// File: tb/tb_encrypt_stream.sv
// Directed bench for encrypt_stream: scaled and unscaled instances share stimulus, and a
// scoreboard of per-row expectations is checked as each ciphertext element is handed off.
module tb_encrypt_stream;

  localparam int PW    = 6;
  localparam int CW    = 10;
  localparam int DIM   = 10;
  localparam int N     = 30;
  localparam int L     = 5;
  localparam int BEATS = N / L;

  logic          clk, rst_n, start, pk_valid, ct_ready;
  logic [PW-1:0] plaintext;
  logic [N-1:0]  noise_select;
  logic [L*CW-1:0] pk_data;

  logic          busy, pk_ready, ct_valid, ct_last, done;
  logic [CW-1:0] ct_data;
  logic [3:0]    ct_index;
  logic          busy0, pk_ready0, ct_valid0, ct_last0, done0;
  logic [CW-1:0] ct_data0;
  logic [3:0]    ct_index0;

  encrypt_stream #(.PT_SCALE(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .plaintext_i(plaintext),
    .noise_select_i(noise_select), .busy_o(busy), .pk_valid_i(pk_valid),
    .pk_ready_o(pk_ready), .pk_data_i(pk_data), .ct_valid_o(ct_valid),
    .ct_ready_i(ct_ready), .ct_data_o(ct_data), .ct_index_o(ct_index),
    .ct_last_o(ct_last), .done_o(done)
  );

  encrypt_stream #(.PT_SCALE(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .plaintext_i(plaintext),
    .noise_select_i(noise_select), .busy_o(busy0), .pk_valid_i(pk_valid),
    .pk_ready_o(pk_ready0), .pk_data_i(pk_data), .ct_valid_o(ct_valid0),
    .ct_ready_i(ct_ready), .ct_data_o(ct_data0), .ct_index_o(ct_index0),
    .ct_last_o(ct_last0), .done_o(done0)
  );

  typedef struct {
    logic [CW-1:0] d1;
    logic [CW-1:0] d0;
    logic [3:0]    idx;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: random entries, 1: lane0 of beat0 = 1000, 2: every entry 1023
  task automatic run_enc(input logic [PW-1:0] pt, input logic [N-1:0] sel, input int mode,
                         input bit bp, input bit inj, input int ab_row, input int ab_beat);
    int            cnt;
    logic [CW-1:0] acc, v, t1, t0;
    exp_t          e;
    plaintext    = pt;
    noise_select = sel;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_low_after_start", done, 0);
    for (int r = 0; r <= DIM; r++) begin
      acc = '0;
      for (int b = 0; b < BEATS; b++) begin
        if (r == ab_row && b == ab_beat) return;
        if (bp) begin
          for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
            pk_valid = 1'b0;
            @(negedge clk);
          end
        end
        for (int l = 0; l < L; l++) begin
          case (mode)
            1:       v = (b == 0 && l == 0) ? 10'd1000 : CW'($urandom_range(0, 1023));
            2:       v = 10'd1023;
            default: v = CW'($urandom_range(0, 1023));
          endcase
          if (sel[b*L+l]) begin
            acc = acc + v;
            pk_data[l*CW +: CW] = v;
          end else if ($urandom_range(0, 1) == 1) begin
            pk_data[l*CW +: CW] = 'x;
          end else begin
            pk_data[l*CW +: CW] = v;
          end
        end
        pk_valid = 1'b1;
        if (inj && r == 1 && b == 1) begin
          start        = 1'b1;
          plaintext    = 6'd9;
          noise_select = ~sel;
        end
        cnt = 0;
        while (!pk_ready && cnt < 20) begin
          @(negedge clk);
          cnt++;
        end
        if (cnt >= 20) check("pk_ready_wait", pk_ready, 1);
        @(negedge clk);
        pk_valid     = 1'b0;
        pk_data      = 'x;
        start        = 1'b0;
        plaintext    = pt;
        noise_select = sel;
      end
      t1 = (r == 0) ? {pt, 4'b0000} : '0;
      t0 = (r == 0) ? {4'b0000, pt} : '0;
      sb.push_back('{d1: acc + t1, d0: acc + t0, idx: 4'(r)});
      check("ct_valid_latency", ct_valid, 1);
      cnt = 0;
      while (!ct_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      if (bp) begin
        for (int k = 0; k < 5; k++) begin
          check("stall_ct_data", ct_data, sb[0].d1);
          check("stall_ct_index", ct_index, sb[0].idx);
          check("stall_pk_ready", pk_ready, 0);
          @(negedge clk);
        end
      end
      e = sb.pop_front();
      check("ct_valid", ct_valid, 1);
      check("ct_data_scaled", ct_data, e.d1);
      check("ct_data_unscaled", ct_data0, e.d0);
      check("ct_index", ct_index, e.idx);
      check("ct_last", ct_last, (r == DIM) ? 1 : 0);
      ct_ready = 1'b1;
      @(negedge clk);
      ct_ready = 1'b0;
      if (r != DIM) check("done_low_mid", done, 0);
    end
    check("done_pulse", done, 1);
    check("busy_after_done", busy, 0);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    pk_valid     = 1'b0;
    ct_ready     = 1'b0;
    plaintext    = '0;
    noise_select = '0;
    pk_data      = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pk_ready", pk_ready, 0);
    check("rst_ct_valid", ct_valid, 0);
    check("rst_ct_data", ct_data, 0);
    check("rst_ct_index", ct_index, 0);
    check("rst_ct_last", ct_last, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_pk_ready", pk_ready, 0);

    run_enc(6'd5, 30'h0, 0, 1'b0, 1'b0, -1, -1);
    // Next run starts in the cycle right after done.
    run_enc(6'd3, 30'h1, 1, 1'b0, 1'b0, -1, -1);
    run_enc(6'd0, 30'h3fff_ffff, 2, 1'b0, 1'b0, -1, -1);
    run_enc(6'd63, 30'h3fff_ffff, 2, 1'b0, 1'b0, -1, -1);
    run_enc(6'd42, 30'h2b5a_c3e1, 0, 1'b1, 1'b0, -1, -1);
    run_enc(6'd17, 30'h1f0f_35a9, 0, 1'b0, 1'b1, -1, -1);

    run_enc(6'd21, 30'h3a5c_0f96, 0, 1'b0, 1'b0, 3, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pk_ready", pk_ready, 0);
    check("midrst_ct_valid", ct_valid, 0);
    check("midrst_ct_data", ct_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_enc(6'd21, 30'h3a5c_0f96, 0, 1'b1, 1'b0, -1, -1);

    @(negedge clk);
    check("final_done_low", done, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/encrypt_stream.md
Name: encrypt_stream

Overview:
- Sequential, lane-parallel LWE encryption engine.
- Consumes the public key one ciphertext row at a time, streamed as LANES entries per beat over a valid/ready input.
- Accumulates the noise-selected entries mod 2^CIPHERTEXT_WIDTH and adds the (optionally scaled) plaintext on row 0.
- Emits all DIMENSION+1 ciphertext elements over a valid/ready output. Sits between the public-key memory reader and the ciphertext sink.

Parameters:
- PLAINTEXT_WIDTH, 6, plaintext bits; plaintext modulus is 2^PLAINTEXT_WIDTH.
- CIPHERTEXT_WIDTH, 10, ciphertext bits; ciphertext modulus is 2^CIPHERTEXT_WIDTH.
- DIMENSION, 10, LWE dimension; DIMENSION+1 ciphertext rows per encryption.
- BIG_N, 30, public-key samples per row; must be a multiple of LANES.
- LANES, 5, public-key entries accepted per beat.
- PT_SCALE, 1, 1: plaintext shifted left by CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH; 0: plaintext zero-extended.
- ROW_WIDTH, 4, index width; must satisfy 2^ROW_WIDTH >= DIMENSION+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin encryption; sampled only in IDLE
- plaintext  in  PLAINTEXT_WIDTH  message; latched on accepted start
- noise_select  in  BIG_N  sample-selection vector; latched on accepted start
- busy  out  1  high whenever state != IDLE
- pk_valid  in  1  public-key beat valid
- pk_ready  out  1  engine can accept a beat
- pk_data  in  LANES*CIPHERTEXT_WIDTH  lane l is bits [l*CW +: CW], sample index beat*LANES+l
- ct_valid  out  1  ciphertext element valid
- ct_ready  in  1  sink accepts element
- ct_data  out  CIPHERTEXT_WIDTH  ciphertext element
- ct_index  out  ROW_WIDTH  row number of ct_data
- ct_last  out  1  high with ct_valid when ct_index == DIMENSION
- done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- BEATS = BIG_N/LANES. States: IDLE, ACCUM, OUTPUT.
- Reset (async, any state): state=IDLE. busy, pk_ready, ct_valid, ct_last and done are 0. ct_data, ct_index, accumulator, row and beat counters are 0. Latched plaintext and noise_select are 0.
- IDLE:
  - start=1 latches plaintext and noise_select, clears row, beat and accumulator, and moves to ACCUM next cycle.
  - start in any other state is ignored; latched values stay unchanged.
- ACCUM:
  - pk_ready=1; a beat transfers when pk_valid && pk_ready.
  - Per transfer: partial = sum over l of (sel[beat*LANES+l] ? lane l : 0). All sums truncate to CIPHERTEXT_WIDTH (mod 2^CW).
  - Non-last beat: acc <= acc+partial, beat++.
  - Last beat (beat==BEATS-1): ct_data <= acc+partial+pt_term, where pt_term = plaintext term if row==0, else 0. Also ct_index <= row, beat <= 0, state -> OUTPUT.
  - No pk_valid means the engine waits; no state change.
- OUTPUT:
  - pk_ready=0 and ct_valid=1.
  - ct_data and ct_index stay stable until ct_valid && ct_ready.
  - On transfer with row==DIMENSION: go to IDLE and pulse done the next cycle.
  - On transfer otherwise: row++, acc=0, go to ACCUM.
- Latency: ct_valid rises the cycle after the last beat of a row is accepted.
- Minimum rate: BEATS+1 cycles per row when no stall occurs.
- Plaintext term:
  - PT_SCALE=1: {plaintext, zeros(CW-PW)}.
  - PT_SCALE=0: plaintext zero-extended.
- Outputs are registered, except pk_ready and ct_valid, which decode state. ct_last = ct_valid && (ct_index==DIMENSION).
- Lanes whose select bit is 0 contribute 0 regardless of pk_data (including X).

Test Plan:
- Reset then idle, defaults -> busy=0, pk_ready=0, ct_valid=0, ct_data=0, done=0. Reasserting rst_n low mid-ACCUM (row 3, beat 2) returns to IDLE next edge; a fresh run then produces correct results.
- plaintext=5, noise_select=0, PT_SCALE=1, arbitrary pk -> 11 elements: index0=80, indices1..10=0. ct_last only on index 10; done pulses once.
- noise_select=30'h1, lane0 of beat0 =1000 on every row, other lanes random, plaintext=3 -> index0=(1000+48) mod 1024=24, indices1..10=1000.
- noise_select all ones, every entry 1023, plaintext=0 -> every element = 30*1023 mod 1024 = 994 (wrap check). With PT_SCALE=0 and plaintext=63, index0=(994+63) mod 1024=33.
- Backpressure: pk_valid random 50%, ct_ready held low 5 cycles per row -> ct_data/ct_index stable while stalled, pk_ready=0 throughout OUTPUT, results identical to the no-stall run.
- start pulsed during ACCUM with new plaintext=9 -> ignored; all outputs match the original plaintext. A start in the cycle after done is accepted.
